// File: rtl/exe_stage_div_pkg.sv
// rtl/exe_stage_div_pkg.sv - shared encodings for the EXE stage with iterative divider
package exe_stage_div_pkg;

    localparam int PASS_W_DEF = 48;

    localparam int DIV_CLS = 2;
    localparam int DIV_SGN = 1;
    localparam int DIV_MOD = 0;

    localparam logic [1:0] SIZE_B = 2'b01;
    localparam logic [1:0] SIZE_H = 2'b10;
    localparam logic [1:0] SIZE_W = 2'b11;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 4'b0001 << addr_lo;
            SIZE_H:  return 4'b0011 << {addr_lo[1], 1'b0};
            SIZE_W:  return 4'hF;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SIZE_B:  return {4{d[7:0]}};
            SIZE_H:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_div_alu.sv
// rtl/exe_stage_div_alu.sv - combinational one-hot ALU
module alu
    import exe_stage_div_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] add_sub;
    logic [4:0]  sh;

    assign add_sub = alu_op[ALU_SUB] ? alu_src1 - alu_src2 : alu_src1 + alu_src2;
    assign sh      = alu_src2[4:0];

    always_comb begin
        alu_result = 32'b0;
        case (1'b1)
            alu_op[ALU_ADD], alu_op[ALU_SUB]: alu_result = add_sub;
            alu_op[ALU_SLT]:  alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
            alu_op[ALU_SLTU]: alu_result = {31'b0, alu_src1 < alu_src2};
            alu_op[ALU_AND]:  alu_result = alu_src1 & alu_src2;
            alu_op[ALU_NOR]:  alu_result = ~(alu_src1 | alu_src2);
            alu_op[ALU_OR]:   alu_result = alu_src1 | alu_src2;
            alu_op[ALU_XOR]:  alu_result = alu_src1 ^ alu_src2;
            alu_op[ALU_SLL]:  alu_result = alu_src1 << sh;
            alu_op[ALU_SRL]:  alu_result = alu_src1 >> sh;
            alu_op[ALU_SRA]:  alu_result = $unsigned($signed(alu_src1) >>> sh);
            alu_op[ALU_LUI]:  alu_result = alu_src2;
            default:          alu_result = 32'b0;
        endcase
    end

endmodule

// File: rtl/exe_stage_div_div_iter.sv
// rtl/exe_stage_div_div_iter.sv - 32-cycle restoring divider on operand magnitudes
module div_iter
    import exe_stage_div_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        flush,
    input  logic        advance,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    div_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] q_r, r_r, b_r;
    logic        q_neg, r_neg;
    logic        a_neg, b_neg;
    logic [32:0] trial;
    logic        ge;

    assign a_neg = is_signed & dividend[31];
    assign b_neg = is_signed & divisor[31];

    // q_r shifts dividend bits out of the top while quotient bits enter at the bottom
    assign trial = {r_r, q_r[31]};
    assign ge    = trial >= {1'b0, b_r};

    always_ff @(posedge clk) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start)          state_nxt = DIV_BUSY;
            DIV_BUSY: if (cnt == 5'd31)   state_nxt = DIV_DONE;
            DIV_DONE: if (advance)        state_nxt = DIV_IDLE;
            default:                      state_nxt = DIV_IDLE;
        endcase
        if (flush) state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            cnt <= 5'd0;
        end else if (state == DIV_IDLE && start) begin
            cnt   <= 5'd0;
            q_r   <= a_neg ? -dividend : dividend;
            b_r   <= b_neg ? -divisor : divisor;
            r_r   <= 32'b0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 5'd1;
            q_r <= {q_r[30:0], ge};
            r_r <= ge ? trial[31:0] - b_r : trial[31:0];
        end
    end

    assign busy = (state == DIV_BUSY);
    assign done = (state == DIV_DONE);
    assign quo  = q_neg ? -q_r : q_r;
    assign rem  = r_neg ? -r_r : r_r;

endmodule

// File: rtl/exe_stage_div.sv
// rtl/exe_stage_div.sv - EXE pipeline stage: ALU, iterative divider, data-SRAM request
module exe_stage_div
    import exe_stage_div_pkg::*;
#(
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_to_exe_valid,
    output logic              exe_allowin,
    input  logic [11:0]       id_alu_op,
    input  logic [31:0]       id_src1,
    input  logic [31:0]       id_src2,
    input  logic [2:0]        id_div_op,
    input  logic              id_mem_we,
    input  logic              id_mem_re,
    input  logic [1:0]        id_mem_size,
    input  logic [31:0]       id_store_data,
    input  logic [PASS_W-1:0] id_passthru,
    input  logic              mem_allowin,
    output logic              exe_to_mem_valid,
    output logic [31:0]       exe_result,
    output logic [PASS_W-1:0] exe_passthru,
    input  logic              mem_flush,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_we,
    output logic [31:0]       data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    output logic              exe_fwd_valid,
    output logic              exe_fwd_busy
);

    logic        exe_valid;
    logic        exe_ready_go;
    logic [11:0] exe_alu_op;
    logic [31:0] exe_src1, exe_src2, exe_store_data;
    logic [2:0]  exe_div_op;
    logic        exe_mem_we, exe_mem_re;
    logic [1:0]  exe_mem_size;
    logic [31:0] alu_result, div_quo, div_rem;
    logic        div_busy, div_done, div_start, is_div;

    always_ff @(posedge clk) begin
        if (!resetn || mem_flush) exe_valid <= 1'b0;
        else if (exe_allowin)     exe_valid <= id_to_exe_valid;
    end

    always_ff @(posedge clk) begin
        if (exe_allowin && id_to_exe_valid) begin
            exe_alu_op     <= id_alu_op;
            exe_src1       <= id_src1;
            exe_src2       <= id_src2;
            exe_div_op     <= id_div_op;
            exe_mem_we     <= id_mem_we;
            exe_mem_re     <= id_mem_re;
            exe_mem_size   <= id_mem_size;
            exe_store_data <= id_store_data;
            exe_passthru   <= id_passthru;
        end
    end

    alu u_alu (
        .alu_op     (exe_alu_op),
        .alu_src1   (exe_src1),
        .alu_src2   (exe_src2),
        .alu_result (alu_result)
    );

    // Start is only requested while the divider sits idle
    assign is_div    = exe_div_op[DIV_CLS];
    assign div_start = exe_valid & is_div & ~div_busy & ~div_done & ~mem_flush;

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .flush     (mem_flush),
        .advance   (mem_allowin),
        .is_signed (exe_div_op[DIV_SGN]),
        .dividend  (exe_src1),
        .divisor   (exe_src2),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    assign exe_ready_go     = ~is_div | div_done;
    assign exe_allowin      = ~exe_valid | (exe_ready_go & mem_allowin);
    assign exe_to_mem_valid = exe_valid & exe_ready_go;
    assign exe_result       = is_div ? (exe_div_op[DIV_MOD] ? div_rem : div_quo) : alu_result;

    // MEM reads data_sram_rdata combinationally, so the request goes out on the advance cycle
    assign data_sram_en    = exe_valid & exe_ready_go & mem_allowin & (exe_mem_we | exe_mem_re) & ~mem_flush;
    assign data_sram_we    = (data_sram_en & exe_mem_we) ? store_mask(exe_mem_size, alu_result[1:0]) : 4'b0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = store_wdata(exe_mem_size, exe_store_data);

    assign exe_fwd_valid = exe_valid;
    assign exe_fwd_busy  = exe_valid & is_div & ~exe_ready_go;

endmodule
